// File: rtl/aes_pkg.sv
// Shared AES front-end definitions: loader state encoding and default staging geometry.
package aes_pkg;

    localparam int unsigned AES_R_DATA_WIDTH = 32;
    localparam int unsigned AES_N_REG        = 8;

    localparam int unsigned LDR_ST_W = 2;
    localparam logic [LDR_ST_W-1:0] ST_FILL = 2'd0;
    localparam logic [LDR_ST_W-1:0] ST_PAD  = 2'd1;
    localparam logic [LDR_ST_W-1:0] ST_HOLD = 2'd2;

endpackage

// File: rtl/sipo_loader_if.sv
// Stream, sipo write-port and block-handshake signals of the sipo loader.
interface sipo_loader_if #(
    parameter int unsigned R_DATA_WIDTH = aes_pkg::AES_R_DATA_WIDTH,
    parameter int unsigned N_REG_BITS   = 3
);
    logic                    s_valid;
    logic                    s_ready;
    logic [R_DATA_WIDTH-1:0] s_data;
    logic                    s_last;
    logic                    load;
    logic [N_REG_BITS-1:0]   addr;
    logic [R_DATA_WIDTH-1:0] din;
    logic                    blk_valid;
    logic                    blk_ready;
    logic                    blk_last;
    logic [N_REG_BITS:0]     blk_words;

    modport master (
        input  s_valid, s_data, s_last, blk_ready,
        output s_ready, load, addr, din, blk_valid, blk_last, blk_words
    );

    modport slave (
        output s_valid, s_data, s_last, blk_ready,
        input  s_ready, load, addr, din, blk_valid, blk_last, blk_words
    );
endinterface

// File: rtl/sipo_loader.sv
// Stream-to-sipo loader: writes words into slots, zero-pads blocks closed early,
// then holds the complete block for the AES core.
module sipo_loader
    import aes_pkg::*;
#(
    parameter int unsigned R_DATA_WIDTH = AES_R_DATA_WIDTH,
    parameter int unsigned N_REG        = AES_N_REG,
    parameter int unsigned N_REG_BITS   = (N_REG == 1) ? 1 : $clog2(N_REG)
) (
    input  logic          clk,
    input  logic          rst,
    sipo_loader_if.master bus
);

    localparam int unsigned CNT_W = N_REG_BITS;
    localparam int unsigned WRD_W = N_REG_BITS + 1;
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(N_REG - 1);

    logic [LDR_ST_W-1:0]     state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    last_q, last_d;
    logic [WRD_W-1:0]        words_q, words_d;
    logic                    s_ready_c;
    logic                    load_c;
    logic [R_DATA_WIDTH-1:0] din_c;
    logic                    hs;

    // State, slot counter and block descriptor registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            words_q <= words_d;
        end
    end

    assign hs = bus.s_valid & s_ready_c;

    // Next-state and write-port decode
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        words_d   = words_q;
        s_ready_c = 1'b0;
        load_c    = 1'b0;
        din_c     = {R_DATA_WIDTH{1'b0}};

        case (state_q)
            ST_FILL: begin
                s_ready_c = 1'b1;
                load_c    = hs;
                din_c     = bus.s_data;
                if (hs) begin
                    words_d = {1'b0, cnt_q} + WRD_W'(1);
                    if (cnt_q == LAST_SLOT) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        last_d  = bus.s_last;
                    end else if (bus.s_last) begin
                        state_d = ST_PAD;
                        cnt_d   = cnt_q + CNT_W'(1);
                        last_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_PAD: begin
                load_c = 1'b1;
                if (cnt_q == LAST_SLOT) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (bus.blk_ready) begin
                    state_d = ST_FILL;
                    last_d  = 1'b0;
                    words_d = '0;
                end
            end
            default: begin
                state_d = ST_FILL;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.s_ready   = s_ready_c;
    assign bus.load      = load_c;
    assign bus.addr      = cnt_q;
    assign bus.din       = din_c;
    assign bus.blk_valid = (state_q == ST_HOLD);
    assign bus.blk_last  = last_q;
    assign bus.blk_words = words_q;

endmodule

// File: tb/tb_sipo_loader.sv
// Randomized self-checking bench for sipo_loader against a block-level reference model.
module tb_sipo_loader;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 8;
    localparam int unsigned AW = 3;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] words [$];
    logic [DW-1:0] sipo_mem [NR];

    sipo_loader_if #(.R_DATA_WIDTH(DW), .N_REG_BITS(AW)) bus ();

    sipo_loader #(.R_DATA_WIDTH(DW), .N_REG(NR), .N_REG_BITS(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the downstream sipo staging register
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR; i++) sipo_mem[i] <= '0;
        end else if (bus.load) begin
            sipo_mem[bus.addr] <= bus.din;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic gen_words(input int n, input bit counting);
        words.delete();
        for (int i = 0; i < n; i++)
            words.push_back(counting ? (32'h1000_0000 + DW'(i)) : DW'($urandom));
    endtask

    // Offer words[0..n-1]; the last one carries last_flag
    task automatic fill_words(input int n, input bit last_flag, input int bubble_pct);
        int idx = 0;
        int guard = 0;
        while (idx < n && guard < 1000) begin
            guard++;
            @(negedge clk);
            bus.s_valid   = ($urandom_range(99) >= bubble_pct);
            bus.s_data    = bus.s_valid ? words[idx] : DW'($urandom);
            bus.s_last    = bus.s_valid ? ((idx == n - 1) ? last_flag : 1'b0) : 1'($urandom_range(1));
            bus.blk_ready = 1'($urandom_range(1));
            #1;
            check("fill_s_ready", 64'(bus.s_ready), 64'(1));
            check("fill_load", 64'(bus.load), 64'(bus.s_valid));
            check("fill_addr", 64'(bus.addr), 64'(idx));
            check("fill_blk_words", 64'(bus.blk_words), 64'(idx));
            check("fill_blk_valid", 64'(bus.blk_valid), 64'(0));
            check("fill_blk_last", 64'(bus.blk_last), 64'(0));
            if (bus.s_valid) begin
                check("fill_din", 64'(bus.din), 64'(words[idx]));
                idx++;
            end
        end
        if (idx < n) check("fill_timeout", 64'(idx), 64'(n));
    endtask

    task automatic run_block(input int n, input bit last_flag, input int bubble_pct, input int hold_cyc);
        logic [DW-1:0] exp_blk [NR];
        for (int i = 0; i < NR; i++) exp_blk[i] = (i < n) ? words[i] : '0;

        fill_words(n, last_flag, bubble_pct);

        for (int p = n; p < NR; p++) begin
            @(negedge clk);
            bus.s_valid   = 1'($urandom_range(1));
            bus.s_data    = DW'($urandom);
            bus.s_last    = 1'($urandom_range(1));
            bus.blk_ready = 1'($urandom_range(1));
            #1;
            check("pad_s_ready", 64'(bus.s_ready), 64'(0));
            check("pad_load", 64'(bus.load), 64'(1));
            check("pad_din", 64'(bus.din), 64'(0));
            check("pad_addr", 64'(bus.addr), 64'(p));
            check("pad_blk_valid", 64'(bus.blk_valid), 64'(0));
        end

        for (int h = 0; h <= hold_cyc; h++) begin
            @(negedge clk);
            bus.s_valid   = 1'b1;
            bus.s_data    = DW'($urandom);
            bus.s_last    = 1'($urandom_range(1));
            bus.blk_ready = (h == hold_cyc);
            #1;
            check("hold_blk_valid", 64'(bus.blk_valid), 64'(1));
            check("hold_blk_words", 64'(bus.blk_words), 64'(n));
            check("hold_blk_last", 64'(bus.blk_last), 64'(last_flag));
            check("hold_s_ready", 64'(bus.s_ready), 64'(0));
            check("hold_load", 64'(bus.load), 64'(0));
            check("hold_addr", 64'(bus.addr), 64'(0));
            if (h == 0)
                for (int i = 0; i < NR; i++)
                    check($sformatf("sipo_slot%0d", i), 64'(sipo_mem[i]), 64'(exp_blk[i]));
        end
    endtask

    initial begin
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.s_last    = 1'b0;
        bus.blk_ready = 1'b0;
        rst = 1'b0;
        #3;
        check("rst_s_ready", 64'(bus.s_ready), 64'(1));
        check("rst_addr", 64'(bus.addr), 64'(0));
        check("rst_blk_valid", 64'(bus.blk_valid), 64'(0));
        check("rst_blk_last", 64'(bus.blk_last), 64'(0));
        check("rst_blk_words", 64'(bus.blk_words), 64'(0));
        check("rst_load_idle", 64'(bus.load), 64'(0));
        bus.s_valid = 1'b1;
        #1;
        check("rst_load_follows", 64'(bus.load), 64'(1));
        bus.s_valid = 1'b0;
        #20;
        rst = 1'b1;

        // Full block, counting pattern, no s_last
        gen_words(NR, 1'b1);
        run_block(NR, 1'b0, 0, 1);

        // Short block closed by s_last, padded
        gen_words(3, 1'b0);
        run_block(3, 1'b1, 0, 0);

        // s_last on the final slot: no padding, held 10 cycles with s_valid high
        gen_words(NR, 1'b0);
        run_block(NR, 1'b1, 0, 10);

        // Random lengths and ~50% valid bubbles
        for (int b = 0; b < 3; b++) begin
            int n;
            bit lf;
            n  = $urandom_range(NR, 1);
            lf = (n < NR) ? 1'b1 : 1'($urandom_range(1));
            gen_words(n, 1'b0);
            run_block(n, lf, 50, $urandom_range(3));
        end

        // Asynchronous reset in the middle of a block
        gen_words(4, 1'b0);
        fill_words(4, 1'b0, 0);
        @(negedge clk);
        bus.s_valid   = 1'b0;
        bus.blk_ready = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_addr", 64'(bus.addr), 64'(0));
        check("mid_rst_s_ready", 64'(bus.s_ready), 64'(1));
        check("mid_rst_blk_words", 64'(bus.blk_words), 64'(0));
        check("mid_rst_blk_valid", 64'(bus.blk_valid), 64'(0));
        check("mid_rst_load", 64'(bus.load), 64'(0));
        #10;
        rst = 1'b1;
        gen_words(2, 1'b0);
        run_block(2, 1'b1, 0, 0);

        @(negedge clk);
        bus.s_valid   = 1'b0;
        bus.blk_ready = 1'b0;
        #1;
        check("turn_s_ready", 64'(bus.s_ready), 64'(1));
        check("turn_addr", 64'(bus.addr), 64'(0));
        check("turn_blk_valid", 64'(bus.blk_valid), 64'(0));
        check("turn_blk_words", 64'(bus.blk_words), 64'(0));
        check("turn_blk_last", 64'(bus.blk_last), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_loader.md
# sipo_loader

Stream-side front end for the AES input staging register (`sipo`). It accepts a valid/ready stream of `R_DATA_WIDTH`-bit words and drives the `load`/`addr`/`din` write port of a `sipo` instance of identical parameters. Once all `N_REG` slots of a block are written, it presents the block to the AES core with a valid/ready handshake. A block closed early by `s_last` is zero-padded, so the `sipo` never holds stale words from a previous block.

## Interface
- `R_DATA_WIDTH`, 32, word width; must equal the downstream `sipo` parameter.
- `N_REG`, 8, words per block.
- `N_REG_BITS`, `(N_REG == 1) ? 1 : $clog2(N_REG)`, slot address width.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  loader accepts a word this cycle.
- `s_data`  in  `R_DATA_WIDTH`  input word.
- `s_last`  in  1  current word is the last of its block; sampled only on a handshake.
- `load`  out  1  write strobe to `sipo`.
- `addr`  out  `N_REG_BITS`  slot index to `sipo`.
- `din`  out  `R_DATA_WIDTH`  write data to `sipo`.
- `blk_valid`  out  1  `sipo` holds a complete block.
- `blk_ready`  in  1  core consumes the block.
- `blk_last`  out  1  block was closed by `s_last`, not by filling all slots.
- `blk_words`  out  `N_REG_BITS+1`  count of real (non-pad) words in the block, range 1..`N_REG`.

## Operation
- FSM states: FILL, PAD, HOLD. Slot counter `cnt`, `N_REG_BITS` wide. `addr` = `cnt` in all states.
- **FILL:**
  - `s_ready`=1; handshake `hs` = `s_valid & s_ready`.
  - `load`=`hs`, `din`=`s_data`.
  - On `hs`, `cnt` increments and `blk_words` is set to `cnt`+1.
- **FILL exit on `hs`:**
  - If `cnt`==`N_REG`-1: go to HOLD, `cnt`←0, `blk_last`←`s_last`.
  - Else if `s_last`: go to PAD, `cnt`←`cnt`+1, `blk_last`←1.
  - Else: stay in FILL.
- **PAD:**
  - `s_ready`=0, `load`=1, `din`=0 every cycle. `cnt` increments each cycle.
  - When `cnt`==`N_REG`-1: final pad write, then go to HOLD with `cnt`←0.
- **HOLD:**
  - `s_ready`=0, `load`=0, `blk_valid`=1.
  - On `blk_ready`: go to FILL; `blk_last`, `blk_words` cleared.
- `blk_ready` outside HOLD is ignored.
- `s_last` with `N_REG`==1 behaves as full: no PAD, `blk_last`=1.
- `din` = `s_data` in FILL and 0 otherwise; `load`=0 outside FILL/PAD.
- **Reset values:** state FILL, `cnt`=0, `blk_valid`=0, `blk_last`=0, `blk_words`=0, `addr`=0, `s_ready`=1. `load` follows `s_valid` (combinational).
- Reset mid-block: counter and flags clear; the `sipo` is cleared by its own reset.

## Timing
- Write latency 0: `load`/`addr`/`din` are combinational from the handshake and counter, so the word lands in `sipo` on the same edge as the handshake.
- `blk_valid` rises in the cycle after the final write (data or pad), which is the first cycle that `sipo` `dout` shows the complete block.
- PAD lasts `N_REG` − `blk_words` cycles, with no bubbles.
- Block turnaround: the `blk_ready` cycle ends HOLD; `s_ready`=1 on the next cycle. Minimum period is `N_REG`+1 cycles per block.
- `blk_valid`, `blk_last` and `blk_words` are stable throughout HOLD regardless of `s_valid`.

## Structure
- Shared package `aes_pkg`: loader state encoding (FILL/PAD/HOLD) and the default `R_DATA_WIDTH`/`N_REG`.
- No sub-module is needed; the counter and FSM are inline.
- The parent instantiates `sipo_loader` and `sipo` side by side, wiring `load`/`addr`/`din` directly.

## Test plan
- Defaults (32/8): 8 back-to-back words 0x1000_0000+i, `s_last`=0 → `load` on 8 consecutive cycles with `addr` 0..7. `blk_valid`=1 on the next cycle, `blk_words`=8, `blk_last`=0, `sipo` `dout` = words in slot order.
- 3 words then `s_last` on the third → 3 data loads at `addr` 0..2, then 5 pad loads at `addr` 3..7 with `din`=0, then `blk_valid`. `blk_words`=3, `blk_last`=1.
- `s_last` on the 8th word → no pad cycles; `blk_valid` next cycle, `blk_words`=8, `blk_last`=1.
- Hold `blk_ready`=0 for 10 cycles with `s_valid`=1 → `s_ready`=0, `load`=0, outputs stable. Assert `blk_ready` → next cycle `s_ready`=1, `addr`=0, first word loads.
- Random `s_valid` bubbles (~50%) over 3 blocks → `addr` advances only on handshakes, and each block's contents match the sent words.
- Drop `rst` asynchronously after 4 words (mid-cycle) → outputs reach reset values immediately. After release, the next word is written to `addr` 0 and `blk_words` counts from 1.
